// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a dead-time gap between digits
// and a double-buffered display register that only updates on frame boundaries.
module seg_scan_ctrl #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned DEADTIME = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_en,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] ShowLast = CntW'(PRESCALE - DEADTIME - 1);
    localparam logic [CntW-1:0] SlotLast = CntW'(PRESCALE - 1);

    typedef enum logic [1:0] {StOff, StShow, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [15:0]     disp_data_q, disp_data_d;
    logic [3:0]      disp_dp_q, disp_dp_d;
    logic [3:0]      disp_blank_q, disp_blank_d;
    logic [15:0]     pend_data_q, pend_data_d;
    logic [3:0]      pend_dp_q, pend_dp_d;
    logic [3:0]      pend_blank_q, pend_blank_d;
    logic            pend_valid_q, pend_valid_d;
    logic            xfer;
    logic [3:0]      nibble;
    logic [6:0]      font;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        frame_done   = 1'b0;
        xfer         = 1'b0;

        case (state_q)
            StOff: begin
                if (enable) begin
                    state_d = StShow;
                    cnt_d   = '0;
                    digit_d = 2'd0;
                    xfer    = pend_valid_q;
                end
            end
            StShow: begin
                if (!enable) begin
                    state_d = StOff;
                    cnt_d   = '0;
                    digit_d = 2'd0;
                end else begin
                    if (cnt_q == ShowLast) state_d = StGap;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (!enable) begin
                    state_d = StOff;
                    cnt_d   = '0;
                    digit_d = 2'd0;
                end else if (cnt_q == SlotLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                    if (digit_q == 2'd3) begin
                        frame_done = 1'b1;
                        xfer       = pend_valid_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
                digit_d = 2'd0;
            end
        endcase

        // Transfer consumes the old pending contents; a same-cycle load refills it.
        if (xfer) begin
            disp_data_d  = pend_data_q;
            disp_dp_d    = pend_dp_q;
            disp_blank_d = pend_blank_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_data_d  = data_in;
            pend_dp_d    = dp_en;
            pend_blank_d = blank;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign nibble = disp_data_q[digit_q*4 +: 4];

    always_comb begin
        unique case (nibble)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    end

    // Outputs depend only on registered state so input glitches never reach the pins.
    always_comb begin
        an  = 4'hF;
        seg = 7'h7F;
        dp  = 1'b1;
        if (state_q == StShow || state_q == StGap) begin
            seg = font;
            dp  = ~disp_dp_q[digit_q];
            if (state_q == StShow && !disp_blank_q[digit_q]) an = ~(4'b0001 << digit_q);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl against a time-arithmetic display model.
module tb_seg_scan_ctrl;

    localparam int P = 8;
    localparam int D = 2;
    localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                         7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                                         7'h06, 7'h0E};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        clk, reset, enable, load;
    logic [15:0] data_in;
    logic [3:0]  dp_en, blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_done;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Model: enabled run time t, from which digit and SHOW/GAP phase follow by division.
    bit          m_on;
    int          m_t;
    logic [15:0] m_dd, m_pd;
    logic [3:0]  m_dpd, m_bd, m_ppd, m_pbd;
    bit          m_pv;

    seg_scan_ctrl #(.PRESCALE(P), .DEADTIME(D)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .data_in(data_in),
        .dp_en(dp_en), .blank(blank), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        m_on = 0; m_t = 0; m_dd = '0; m_pd = '0; m_dpd = '0; m_bd = '0;
        m_ppd = '0; m_pbd = '0; m_pv = 0;
    endfunction

    function automatic exp_t model_out(logic en);
        exp_t r;
        int pos, dig, w;
        logic [3:0] nib;
        if (!m_on) return '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
        pos = m_t % (4 * P);
        dig = pos / P;
        w   = pos % P;
        nib = m_dd[dig*4 +: 4];
        r.seg = FONT[nib];
        r.dp  = ~m_dpd[dig];
        r.an  = (w < P - D && !m_bd[dig]) ? ~(4'b0001 << dig) : 4'hF;
        r.fd  = en && (pos == 4 * P - 1);
        return r;
    endfunction

    function automatic void model_step(logic en, logic ld, logic [15:0] d, logic [3:0] dpv,
                                       logic [3:0] bl);
        bit xfer = 0;
        if (!m_on) begin
            if (en) begin m_on = 1; m_t = 0; xfer = m_pv; end
        end else if (!en) begin
            m_on = 0;
        end else begin
            if (m_t % (4 * P) == 4 * P - 1) xfer = m_pv;
            m_t++;
        end
        if (xfer) begin m_dd = m_pd; m_dpd = m_ppd; m_bd = m_pbd; m_pv = 0; end
        if (ld) begin m_pd = d; m_ppd = dpv; m_pbd = bl; m_pv = 1; end
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic en, input logic ld, input logic [15:0] d,
                         input logic [3:0] dpv, input logic [3:0] bl);
        enable = en; load = ld; data_in = d; dp_en = dpv; blank = bl;
        exp_q.push_back(model_out(en));
        @(posedge clk);
        model_step(en, ld, d, dpv, bl);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL %s: got an=%h seg=%h dp=%b fd=%b, need an=f seg=7f dp=1 fd=0",
                     name, an, seg, dp, frame_done);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
                failures++;
                $display("FAIL scan @%0t: got an=%h seg=%h dp=%b fd=%b, need an=%h seg=%h dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
    end

    initial begin
        logic en_r;
        reset = 1'b1; enable = 1'b0; load = 1'b0; data_in = '0; dp_en = '0; blank = '0;
        model_reset();
        #2 check_reset_outputs("power_on_reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Load coincides with enable: first frame stays 0000, then 1234 appears.
        cycle(1'b1, 1'b1, 16'h1234, 4'b0000, 4'b0000);
        repeat (80) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // Mid-frame load, then a load on the frame_done cycle.
        cycle(1'b1, 1'b1, 16'hABCD, 4'b0000, 4'b0000);
        while (!(m_on && m_t % (4 * P) == 4 * P - 1)) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        cycle(1'b1, 1'b1, 16'hEF01, 4'b0001, 4'b0100);
        repeat (100) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // Drop enable during digit-2 SHOW, then re-enable.
        while (!(m_on && m_t % (4 * P) == 2 * P + 1)) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        repeat (40) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // Random traffic.
        en_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) en_r = ~en_r;
            cycle(en_r, ($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom),
                  4'($urandom));
        end

        // Async reset between edges during digit-1 SHOW.
        while (!(m_on && m_t % (4 * P) == P + 1)) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        enable = 1'b1; load = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset_mid_frame");
        @(posedge clk); #1;
        check_reset_outputs("reset_held");
        reset = 1'b0;
        model_reset();
        repeat (80) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        en_r = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) en_r = ~en_r;
            cycle(en_r, ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
                  4'($urandom));
        end

        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
